tlb_plru_replacer: RTL and testbench

Victim-selection stage for the TLB, directly upstream of the TLB RAM and CAM. Keeps a tree pseudo-LRU state across all entries, updated on every TLB hit and every TLB fill. When the page-table walker requests a fill, the block drives the one-hot `WriteEnables` vector consumed by the TLB RAM and CAM. Empty (invalid) entries are always filled before any valid entry is evicted.

---
 rtl/tlb_plru_if.sv | 35 +++
 rtl/tlb_plru_replacer.sv | 92 +++++++++
 tb/tb_tlb_plru_replacer.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/tlb_plru_if.sv
// Fill/hit/flush handshake between the TLB control path and the PLRU victim selector.
// The master drives requests and CAM status. The slave returns the fill target.
interface tlb_plru_if #(
    parameter int TLB_ENTRIES = 8
) ();
    localparam int LOGN = $clog2(TLB_ENTRIES);

    logic                   TLBWrite;
    logic                   TLBFlush;
    logic                   TLBHit;
    logic [TLB_ENTRIES-1:0] Matches;
    logic [TLB_ENTRIES-1:0] Valid;
    logic [TLB_ENTRIES-1:0] WriteEnables;
    logic [LOGN-1:0]        VictimIndex;

    modport master (
        output TLBWrite,
        output TLBFlush,
        output TLBHit,
        output Matches,
        output Valid,
        input  WriteEnables,
        input  VictimIndex
    );

    modport slave (
        input  TLBWrite,
        input  TLBFlush,
        input  TLBHit,
        input  Matches,
        input  Valid,
        output WriteEnables,
        output VictimIndex
    );
endinterface

// File: rtl/tlb_plru_replacer.sv
// Tree pseudo-LRU victim selector for the TLB.
// Invalid entries are filled first. Otherwise the victim is found by walking the PLRU tree.
module tlb_plru_replacer #(
    parameter int TLB_ENTRIES = 8
) (
    input  logic          clk,
    input  logic          reset,
    tlb_plru_if.slave     bus
);
    localparam int LOGN  = $clog2(TLB_ENTRIES);
    localparam int NODES = TLB_ENTRIES - 1;

    logic [NODES-1:0]       r_plru;
    logic [NODES-1:0]       w_plru_next;
    logic [LOGN-1:0]        w_tree_idx;
    logic [LOGN-1:0]        w_inv_idx;
    logic                   w_any_invalid;
    logic [LOGN-1:0]        w_victim;
    logic [LOGN-1:0]        w_match_idx;
    logic                   w_any_match;
    logic [TLB_ENTRIES-1:0] w_write_en;

    // Each node on the path to idx is pointed at the sibling subtree.
    function automatic logic [NODES-1:0] touch(input logic [NODES-1:0] plru,
                                               input logic [LOGN-1:0]  idx);
        logic [NODES-1:0] t;
        int               node;
        t = plru;
        for (int lvl = 0; lvl < LOGN; lvl++) begin
            node    = (1 << lvl) - 1 + int'(idx >> (LOGN - lvl));
            t[node] = ~idx[LOGN-1-lvl];
        end
        return t;
    endfunction

    always_comb begin
        int   node;
        logic b;
        w_tree_idx = '0;
        node       = 0;
        for (int lvl = 0; lvl < LOGN; lvl++) begin
            b                      = r_plru[node];
            w_tree_idx[LOGN-1-lvl] = b;
            node                   = 2 * node + 1 + int'(b);
        end
    end

    always_comb begin
        w_inv_idx = '0;
        for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
            if (!bus.Valid[i]) begin
                w_inv_idx = i[LOGN-1:0];
            end
        end
    end

    always_comb begin
        w_match_idx = '0;
        for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
            if (bus.Matches[i]) begin
                w_match_idx = i[LOGN-1:0];
            end
        end
    end

    assign w_any_invalid = ~&bus.Valid;
    assign w_any_match   = |bus.Matches;
    assign w_victim      = w_any_invalid ? w_inv_idx : w_tree_idx;
    assign w_write_en    = bus.TLBWrite ? (TLB_ENTRIES'(1) << w_victim) : '0;

    always_comb begin
        w_plru_next = r_plru;
        if (bus.TLBFlush) begin
            w_plru_next = '0;
        end else if (bus.TLBWrite) begin
            w_plru_next = touch(r_plru, w_victim);
        end else if (bus.TLBHit && w_any_match) begin
            w_plru_next = touch(r_plru, w_match_idx);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_plru <= '0;
        end else begin
            r_plru <= w_plru_next;
        end
    end

    assign bus.WriteEnables = w_write_en;
    assign bus.VictimIndex  = w_victim;
endmodule

// File: tb/tb_tlb_plru_replacer.sv
// Directed bench for tlb_plru_replacer with 8 entries and hand-computed tree states.
module tb_tlb_plru_replacer;
    logic clk;
    logic reset;
    int   errors;
    int   checks;

    tlb_plru_if #(.TLB_ENTRIES(8)) bus ();

    tlb_plru_replacer #(.TLB_ENTRIES(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.TLBWrite = 1'b0;
        bus.TLBFlush = 1'b0;
        bus.TLBHit   = 1'b0;
        bus.Matches  = 8'h00;
    endtask

    task automatic test_reset();
        idle();
        bus.Valid = 8'hFF;
        reset     = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if (dut.r_plru !== 7'b0000000) begin
            errors++;
            $display("FAIL reset_plru actual=%b expected=%b", dut.r_plru, 7'b0000000);
        end
        checks++;
        if (bus.WriteEnables !== 8'h00) begin
            errors++;
            $display("FAIL reset_we actual=%h expected=%h", bus.WriteEnables, 8'h00);
        end
        checks++;
        if (bus.VictimIndex !== 3'd0) begin
            errors++;
            $display("FAIL reset_victim actual=%0d expected=%0d", bus.VictimIndex, 0);
        end
        bus.Valid = 8'hEF;
        #1;
        checks++;
        if (bus.VictimIndex !== 3'd4) begin
            errors++;
            $display("FAIL reset_victim_invalid actual=%0d expected=%0d", bus.VictimIndex, 4);
        end
        bus.Valid = 8'hFF;
    endtask

    task automatic test_fill_sequence();
        bus.TLBWrite = 1'b1;
        #1;
        checks++;
        if (bus.WriteEnables !== 8'h01 || bus.VictimIndex !== 3'd0) begin
            errors++;
            $display("FAIL fill0 we=%h idx=%0d expected we=01 idx=0", bus.WriteEnables, bus.VictimIndex);
        end
        tick();
        checks++;
        if (dut.r_plru !== 7'b0001011) begin
            errors++;
            $display("FAIL fill0_plru actual=%b expected=%b", dut.r_plru, 7'b0001011);
        end
        checks++;
        if (bus.WriteEnables !== 8'h10 || bus.VictimIndex !== 3'd4) begin
            errors++;
            $display("FAIL fill1 we=%h idx=%0d expected we=10 idx=4", bus.WriteEnables, bus.VictimIndex);
        end
        tick();
        checks++;
        if (dut.r_plru !== 7'b0101110) begin
            errors++;
            $display("FAIL fill1_plru actual=%b expected=%b", dut.r_plru, 7'b0101110);
        end
        bus.TLBWrite = 1'b0;
        #1;
        checks++;
        if (bus.WriteEnables !== 8'h00 || bus.VictimIndex !== 3'd2) begin
            errors++;
            $display("FAIL fill2_idle we=%h idx=%0d expected we=00 idx=2", bus.WriteEnables, bus.VictimIndex);
        end
    endtask

    task automatic test_invalid_priority();
        bus.Valid    = 8'hF7;
        bus.TLBWrite = 1'b1;
        #1;
        checks++;
        if (bus.WriteEnables !== 8'h08 || bus.VictimIndex !== 3'd3) begin
            errors++;
            $display("FAIL invalid_f7 we=%h idx=%0d expected we=08 idx=3", bus.WriteEnables, bus.VictimIndex);
        end
        tick();
        checks++;
        if (dut.r_plru !== 7'b0101101) begin
            errors++;
            $display("FAIL invalid_f7_plru actual=%b expected=%b", dut.r_plru, 7'b0101101);
        end
        bus.Valid = 8'h00;
        #1;
        checks++;
        if (bus.WriteEnables !== 8'h01 || bus.VictimIndex !== 3'd0) begin
            errors++;
            $display("FAIL invalid_00 we=%h idx=%0d expected we=01 idx=0", bus.WriteEnables, bus.VictimIndex);
        end
        bus.TLBWrite = 1'b0;
        bus.Valid    = 8'hFF;
        #1;
    endtask

    task automatic test_hit_sweep();
        bus.TLBHit = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.Matches = 8'(1 << i);
            #1;
            checks++;
            if (bus.WriteEnables !== 8'h00) begin
                errors++;
                $display("FAIL hit_sweep_we entry=%0d actual=%h expected=00", i, bus.WriteEnables);
            end
            tick();
        end
        idle();
        #1;
        checks++;
        if (dut.r_plru !== 7'b0000000 || bus.VictimIndex !== 3'd0) begin
            errors++;
            $display("FAIL hit_sweep_end plru=%b idx=%0d expected plru=0000000 idx=0", dut.r_plru, bus.VictimIndex);
        end
    endtask

    task automatic test_flush_write();
        bus.TLBHit  = 1'b1;
        bus.Matches = 8'h01;
        tick();
        bus.TLBFlush = 1'b1;
        bus.TLBWrite = 1'b1;
        #1;
        checks++;
        if (bus.WriteEnables !== 8'h10) begin
            errors++;
            $display("FAIL flush_write_we actual=%h expected=10", bus.WriteEnables);
        end
        tick();
        idle();
        #1;
        checks++;
        if (dut.r_plru !== 7'b0000000 || bus.VictimIndex !== 3'd0) begin
            errors++;
            $display("FAIL flush_write_plru plru=%b idx=%0d expected plru=0000000 idx=0", dut.r_plru, bus.VictimIndex);
        end
    endtask

    task automatic test_hit_edge();
        bus.TLBHit  = 1'b1;
        bus.Matches = 8'h00;
        tick();
        checks++;
        if (dut.r_plru !== 7'b0000000) begin
            errors++;
            $display("FAIL hit_nomatch actual=%b expected=%b", dut.r_plru, 7'b0000000);
        end
        bus.Matches = 8'h60;
        tick();
        checks++;
        if (dut.r_plru !== 7'b0000100) begin
            errors++;
            $display("FAIL hit_multi actual=%b expected=%b", dut.r_plru, 7'b0000100);
        end
        bus.Matches  = 8'h80;
        bus.TLBWrite = 1'b1;
        #1;
        checks++;
        if (bus.WriteEnables !== 8'h01) begin
            errors++;
            $display("FAIL write_hit_we actual=%h expected=01", bus.WriteEnables);
        end
        tick();
        idle();
        #1;
        checks++;
        if (dut.r_plru !== 7'b0001111 || bus.VictimIndex !== 3'd6) begin
            errors++;
            $display("FAIL write_hit_plru plru=%b idx=%0d expected plru=0001111 idx=6", dut.r_plru, bus.VictimIndex);
        end
    endtask

    task automatic test_reset_mid_fill();
        reset        = 1'b1;
        bus.TLBWrite = 1'b1;
        #1;
        checks++;
        if (bus.WriteEnables !== 8'h40) begin
            errors++;
            $display("FAIL reset_fill_we actual=%h expected=40", bus.WriteEnables);
        end
        tick();
        reset = 1'b0;
        idle();
        #1;
        checks++;
        if (dut.r_plru !== 7'b0000000 || bus.WriteEnables !== 8'h00) begin
            errors++;
            $display("FAIL reset_fill_plru plru=%b we=%h expected plru=0000000 we=00", dut.r_plru, bus.WriteEnables);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b1;
        idle();
        bus.Valid = 8'hFF;
        test_reset();
        test_fill_sequence();
        test_invalid_priority();
        test_hit_sweep();
        test_flush_write();
        test_hit_edge();
        test_reset_mid_fill();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
